// File: rtl/ppc_types.sv
// Shared PowerPC core constants: writeback unit numbering and GPR geometry.
package ppc_types;

   localparam int GPR_WB_NUM_REQ = 4;
   localparam int GPR_ADDR_WIDTH = 5;
   localparam int GPR_DATA_WIDTH = 32;

   // Execution-unit index on the shared GPR writeback arbiter.
   localparam int UNIT_ALU    = 0;
   localparam int UNIT_MULDIV = 1;
   localparam int UNIT_LDST   = 2;
   localparam int UNIT_SYS    = 3;

   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/gpr_writeback_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping.
module rr_pick #(
   parameter int N         = 4,
   parameter int IDX_WIDTH = $clog2(N)
) (
   input  logic [0:N-1]         i_req,
   input  logic [0:IDX_WIDTH-1] i_ptr,
   output logic [0:N-1]         o_grant,
   output logic [0:IDX_WIDTH-1] o_idx,
   output logic                 o_any
);

   int w_pos;

   always_comb begin
      // NOTE: every output gets a default before the search, so no latch is inferred.
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      w_pos   = 0;
      for (int k = 0; k < N; k++) begin
         w_pos = int'(i_ptr) + k;
         if (w_pos >= N) w_pos = w_pos - N;
         if (!o_any && i_req[IDX_WIDTH'(w_pos)]) begin
            o_any                      = 1'b1;
            o_grant[IDX_WIDTH'(w_pos)] = 1'b1;
            o_idx                      = IDX_WIDTH'(w_pos);
         end
      end
   end

endmodule

// File: rtl/gpr_writeback_arbiter.sv
// Shares one registered GPR writeback port among NUM_REQ execution-unit result buses
// with round-robin fairness; the pointer only moves past a unit that was actually granted.
module gpr_writeback_arbiter
   import ppc_types::*;
#(
   parameter int RS_ID_WIDTH = 5,
   parameter int NUM_REQ     = GPR_WB_NUM_REQ
) (
   input  logic                                           clk,
   input  logic                                           rst,
   input  logic [0:NUM_REQ-1]                             req_valid,
   output logic [0:NUM_REQ-1]                             req_ready,
   input  logic [0:NUM_REQ-1][0:RS_ID_WIDTH-1]            req_rs_id,
   input  logic [0:NUM_REQ-1][0:GPR_ADDR_WIDTH-1]         req_reg_addr,
   input  logic [0:NUM_REQ-1][0:GPR_DATA_WIDTH-1]         req_result,
   output logic                                           out_valid,
   input  logic                                           out_ready,
   output logic [0:RS_ID_WIDTH-1]                         out_rs_id,
   output logic [0:GPR_ADDR_WIDTH-1]                      out_reg_addr,
   output logic [0:GPR_DATA_WIDTH-1]                      out_result,
   output logic [0:$clog2(NUM_REQ)-1]                     out_src
);

   localparam int SRC_WIDTH = $clog2(NUM_REQ);

   logic                        r_out_valid;
   logic [0:SRC_WIDTH-1]        r_out_src;
   logic [0:RS_ID_WIDTH-1]      r_out_rs_id;
   logic [0:GPR_ADDR_WIDTH-1]   r_out_reg_addr;
   logic [0:GPR_DATA_WIDTH-1]   r_out_result;
   logic [0:SRC_WIDTH-1]        r_rr_ptr;

   logic                        w_free;
   logic [0:NUM_REQ-1]          w_pick_grant;
   logic [0:SRC_WIDTH-1]        w_pick_idx;
   logic                        w_pick_any;

   // The single output slot can take a new entry when empty or being drained this cycle.
   assign w_free = !r_out_valid || out_ready;

   rr_pick #(
      .N         (NUM_REQ),
      .IDX_WIDTH (SRC_WIDTH)
   ) u_rr_pick (
      .i_req   (req_valid),
      .i_ptr   (r_rr_ptr),
      .o_grant (w_pick_grant),
      .o_idx   (w_pick_idx),
      .o_any   (w_pick_any)
   );

   always_comb begin
      req_ready = '0;
      if (!rst && w_free) req_ready = w_pick_grant;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: payload flops are reset as well, so out_* read as zero while rst is high.
         r_out_valid    <= 1'b0;
         r_out_src      <= '0;
         r_out_rs_id    <= '0;
         r_out_reg_addr <= '0;
         r_out_result   <= '0;
         r_rr_ptr       <= '0;
      end else if (w_free) begin
         if (w_pick_any) begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            r_out_valid    <= 1'b1;
            r_out_src      <= w_pick_idx;
            r_out_rs_id    <= req_rs_id[w_pick_idx];
            r_out_reg_addr <= req_reg_addr[w_pick_idx];
            r_out_result   <= req_result[w_pick_idx];
            r_rr_ptr       <= SRC_WIDTH'(wrap_inc(int'(w_pick_idx), NUM_REQ));
         end else begin
            r_out_valid    <= 1'b0;
         end
      end
   end

   assign out_valid    = r_out_valid;
   assign out_src      = r_out_src;
   assign out_rs_id    = r_out_rs_id;
   assign out_reg_addr = r_out_reg_addr;
   assign out_result   = r_out_result;

endmodule

// File: tb/tb_gpr_writeback_arbiter.sv
// Directed and scoreboarded random checks for the GPR writeback arbiter (4 units).
module tb_gpr_writeback_arbiter;

   localparam int N = 4;

   logic                  clk;
   logic                  rst;
   logic [0:N-1]          req_valid;
   logic [0:N-1]          req_ready;
   logic [0:N-1][0:4]     req_rs_id;
   logic [0:N-1][0:4]     req_reg_addr;
   logic [0:N-1][0:31]    req_result;
   logic                  out_valid;
   logic                  out_ready;
   logic [0:4]            out_rs_id;
   logic [0:4]            out_reg_addr;
   logic [0:31]           out_result;
   logic [0:1]            out_src;

   int n_checks = 0;
   int n_errors = 0;

   gpr_writeback_arbiter #(
      .RS_ID_WIDTH (5),
      .NUM_REQ     (N)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_rs_id    (req_rs_id),
      .req_reg_addr (req_reg_addr),
      .req_result   (req_result),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_rs_id    (out_rs_id),
      .out_reg_addr (out_reg_addr),
      .out_result   (out_result),
      .out_src      (out_src)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Masks use conventional numbering: bit i of the mask is unit i.
   task automatic set_valid(input logic [3:0] m);
      for (int i = 0; i < N; i++) req_valid[i] = m[i];
   endtask

   function automatic logic [3:0] ready_mask();
      logic [3:0] m;
      for (int i = 0; i < N; i++) m[i] = req_ready[i];
      return m;
   endfunction

   function automatic logic [31:0] def_result(input int i);
      return 32'hA000_0000 + 32'(i);
   endfunction

   task automatic set_default_payload(input int i);
      req_rs_id[i]    = 5'(5'h10 + i);
      req_reg_addr[i] = 5'(i + 4);
      req_result[i]   = def_result(i);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard state for the random phase.
   logic [43:0] sb_q[$];
   logic [43:0] sb_exp;
   logic [43:0] sb_got;
   logic [3:0]  exp_mask;
   bit          pend[N];
   int          waits[N];
   int          m_ptr;
   int          w;
   bit          m_free;
   int          g_seq[5] = '{0, 1, 2, 3, 0};

   initial begin
      rst       = 1'b1;
      out_ready = 1'b0;
      req_valid = '0;
      for (int i = 0; i < N; i++) set_default_payload(i);
      set_valid(4'b1111);

      // Reset state, with every unit requesting.
      repeat (2) @(posedge clk);
      #2;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_src", out_src, 0);
      check("rst_out_rs_id", out_rs_id, 0);
      check("rst_out_reg_addr", out_reg_addr, 0);
      check("rst_out_result", out_result, 0);
      check("rst_req_ready", ready_mask(), 0);

      // Idle after reset: nothing requested for 5 cycles.
      tick();
      rst = 1'b0;
      set_valid(4'b0000);
      out_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #1;
         check("idle_req_ready", ready_mask(), 0);
         tick();
         check("idle_out_valid", out_valid, 0);
      end

      // All four valid, out_ready held: grants 0,1,2,3,0.
      set_valid(4'b1111);
      for (int k = 0; k < 5; k++) begin
         #1;
         check("rr_grant", ready_mask(), 4'b0001 << g_seq[k]);
         tick();
         check("rr_out_valid", out_valid, 1);
         check("rr_out_src", out_src, g_seq[k]);
         check("rr_out_result", out_result, def_result(g_seq[k]));
      end
      set_valid(4'b0000);
      #1;
      check("rr_drain_ready", ready_mask(), 0);
      tick();
      check("rr_drain_valid", out_valid, 0);

      // Stall: unit 2 result held while out_ready is low.
      req_rs_id[2]    = 5'h0A;
      req_reg_addr[2] = 5'd7;
      req_result[2]   = 32'hDEADBEEF;
      set_valid(4'b0100);
      out_ready = 1'b0;
      #1;
      check("stall_grant", ready_mask(), 4'b0100);
      tick();
      set_valid(4'b1111);
      for (int c = 0; c < 3; c++) begin
         check("stall_out_valid", out_valid, 1);
         check("stall_out_src", out_src, 2);
         check("stall_out_rs_id", out_rs_id, 5'h0A);
         check("stall_out_reg_addr", out_reg_addr, 5'd7);
         check("stall_out_result", out_result, 32'hDEADBEEF);
         #1;
         check("stall_req_ready", ready_mask(), 0);
         tick();
      end
      set_valid(4'b0000);
      out_ready = 1'b1;
      #1;
      check("stall_release_ready", ready_mask(), 0);
      tick();
      check("stall_release_valid", out_valid, 0);
      set_default_payload(2);

      // Pointer now sits at 3: units 0 and 1 valid -> wrap to 0, then 1.
      set_valid(4'b0011);
      #1;
      check("wrap_grant0", ready_mask(), 4'b0001);
      tick();
      check("wrap_src0", out_src, 0);
      check("wrap_result0", out_result, def_result(0));
      #1;
      check("wrap_grant1", ready_mask(), 4'b0010);
      tick();
      check("wrap_src1", out_src, 1);
      set_valid(4'b0000);
      tick();
      check("wrap_drain_valid", out_valid, 0);

      // Reset during a stall discards the entry and the pointer.
      set_valid(4'b0100);
      out_ready = 1'b0;
      tick();
      check("rststall_loaded", out_valid, 1);
      set_valid(4'b0000);
      tick();
      check("rststall_held", out_valid, 1);
      rst = 1'b1;
      #1;
      check("rststall_async_valid", out_valid, 0);
      check("rststall_async_result", out_result, 0);
      tick();
      rst = 1'b0;
      set_valid(4'b1010);
      out_ready = 1'b1;
      #1;
      check("rststall_first_grant", ready_mask(), 4'b0010);
      tick();
      check("rststall_src", out_src, 1);
      check("rststall_out_valid", out_valid, 1);

      // Random traffic against a scoreboard.
      rst = 1'b1;
      set_valid(4'b0000);
      tick();
      rst = 1'b0;
      m_ptr = 0;
      for (int i = 0; i < N; i++) begin
         pend[i]  = 1'b0;
         waits[i] = 0;
      end
      for (int c = 0; c < 10000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(0, 1) == 1) begin
               pend[i]         = 1'b1;
               req_rs_id[i]    = 5'($urandom_range(0, 31));
               req_reg_addr[i] = 5'($urandom_range(0, 31));
               req_result[i]   = $urandom;
            end
            req_valid[i] = pend[i];
         end
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         check("rand_out_valid", out_valid, sb_q.size() != 0);
         m_free   = (sb_q.size() == 0) || out_ready;
         exp_mask = '0;
         w        = -1;
         if (m_free) begin
            for (int k = 0; k < N; k++) begin
               if (w < 0 && pend[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            end
         end
         if (w >= 0) exp_mask[w] = 1'b1;
         check("rand_grant", ready_mask(), exp_mask);
         if (sb_q.size() != 0 && out_ready) begin
            sb_exp = sb_q.pop_front();
            sb_got = {out_src, out_rs_id, out_reg_addr, out_result};
            check("rand_out_entry", sb_got, sb_exp);
         end
         if (w >= 0) begin
            sb_q.push_back({2'(w), req_rs_id[w], req_reg_addr[w], req_result[w]});
            check("rand_starvation", waits[w] < N, 1);
            waits[w] = 0;
            pend[w]  = 1'b0;
            for (int i = 0; i < N; i++) if (pend[i]) waits[i]++;
            m_ptr = (w + 1) % N;
         end
         tick();
      end

      // Drain whatever is still in the output slot.
      set_valid(4'b0000);
      out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         if (sb_q.size() != 0) begin
            sb_exp = sb_q.pop_front();
            sb_got = {out_src, out_rs_id, out_reg_addr, out_result};
            check("drain_out_entry", sb_got, sb_exp);
         end
         tick();
      end
      check("drain_queue_empty", sb_q.size(), 0);
      check("drain_out_valid", out_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
